bpu_update_ctrl: RTL and testbench
==================================

Name: bpu_update_ctrl

Overview:
Sequences all writes into the 32-entry branch prediction unit.
- After reset or a flush request, walks every BPU entry and invalidates it.
- Otherwise buffers branch-resolution updates from ID in a small FIFO and drains them into the BPU write port one per cycle, honouring the pipeline pause.
- Sits between the ID-stage branch resolution logic and the BPU write port (wen/index/pc_4/target).

Parameters:
ENTRIES, 32, number of BPU entries; clear walk length; index width is log2(ENTRIES)=5
QDEPTH, 4, update FIFO depth (power of 2, >=2)
CLEAR_TAG, 32'hFFFF_FFFF, pc_4 value written during clear; never a legal PC+4

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
pause_i  in  1  pipeline pause; no BPU write may be issued while high
flush_req_i  in  1  one-cycle pulse: discard queue, re-run clear walk
res_valid_i  in  1  branch resolution update present
res_taken_i  in  1  resolved direction; becomes the BPU predict bit
res_index_i  in  5  BPU index carried down from IF
res_pc_4_i  in  32  PC+4 of the branch
res_target_i  in  32  resolved branch target
res_ready_o  out  1  FIFO not full
bpu_wen_o  out  2  [1]=write enable, [0]=predict bit
bpu_index_o  out  5  entry written
bpu_pc_4_o  out  32  tag written
bpu_target_o  out  32  target written
busy_o  out  1  high in CLEAR
drop_cnt_o  out  8  saturating count of updates lost to a full FIFO

Behaviour:
- Async reset: state=CLEAR, clr_idx=0, FIFO empty, drop_cnt_o=0. All outputs are combinational from state/FIFO head:
  - bpu_wen_o=2'b10, bpu_index_o=0, bpu_pc_4_o=CLEAR_TAG, bpu_target_o=0
  - busy_o=1, res_ready_o=1
- FSM states are CLEAR and RUN.
- CLEAR:
  - Drive wen=2'b10, index=clr_idx, pc_4=CLEAR_TAG, target=0 (predict bit 0).
  - On each edge with pause_i=0: clr_idx++.
  - On the edge where clr_idx==ENTRIES-1 and pause_i=0: go to RUN, clr_idx=0.
  - pause_i=1 holds clr_idx; the outputs stay stable.
  - The walk takes exactly ENTRIES unpaused cycles.
- RUN:
  - FIFO empty: bpu_wen_o=2'b00. Index, pc_4 and target show the head slot, which is don't-care.
  - FIFO not empty: wen={1'b1, head.taken}, index/pc_4/target come from the head.
  - The head pops on an edge with pause_i=0. Nothing pops while paused.
- Enqueue: on an edge with res_valid_i=1 and the FIFO not full (counting the same-cycle pop as not freeing space). Enqueue is accepted in both CLEAR and RUN; queued entries drain only in RUN.
- Latency: an update accepted at edge N is presented at the BPU port in cycle N+1 (empty FIFO, no pause), and is written at edge N+1.
- Full FIFO with res_valid_i=1: the update is dropped and drop_cnt_o increments, saturating at 8'hFF.
  - res_ready_o=!full.
  - Simultaneous pop and push when full: the push is still dropped. This keeps res_ready_o free of any combinational path from pause_i.
- Pointers: read and write pointers are log2(QDEPTH)+1 bits and wrap modulo 2*QDEPTH. full and empty come from pointer MSB/LSB comparison.
- flush_req_i=1 on an edge, taking priority over everything else:
  - FIFO emptied; a same-cycle res_valid_i is discarded and not counted as a drop.
  - state=CLEAR, clr_idx=0. This applies even mid-CLEAR, where the walk restarts.
  - A same-cycle pop/write still occurs at the BPU, because the BPU samples independently.
- Reset asserted mid-walk or mid-drain: immediate return to reset values. No partial state survives.
- drop_cnt_o is cleared only by reset, not by flush.

Decomposition:
- Shared package (bpu_pkg): BPU_ENTRIES=32, BPU_IDX_W=5, BPU_CLEAR_TAG, and the update record type {taken, index[4:0], pc_4[31:0], target[31:0]} (70 bits).
- One natural sub-module: bpu_upd_fifo.
  - Parameterised synchronous FIFO of the update record.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous active-high reset.
- The FSM and the clear counter stay in bpu_update_ctrl.

Test Plan:
1. Release reset, pause_i=0 -> 32 consecutive cycles with wen=2'b10, index 0..31, pc_4=32'hFFFF_FFFF; busy_o falls after index 31; wen=2'b00 after that.
2. Pause during clear: pause_i=1 for 3 cycles at clr_idx=10 -> index holds at 10 for 3 cycles; the walk completes in 35 total cycles.
3. In RUN, push {taken=1, idx=5, pc_4=32'h0040_0008, tgt=32'h0040_0100} -> next cycle wen=2'b11, index=5, same pc_4/tgt; then wen=2'b00.
4. pause_i=1, push 5 updates back-to-back -> res_ready_o falls after 4; drop_cnt_o=1; releasing pause drains the 4 in FIFO order on 4 consecutive cycles.
5. Two queued entries, flush_req_i pulse together with res_valid_i -> queue empty, drop_cnt_o unchanged, busy_o=1, walk restarts at index 0.
6. Assert reset at clr_idx=20 and during a drain -> outputs return to reset values at once; the walk restarts at 0 after release.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit write path.
//
// Contents:
//   BPU_ENTRIES    number of BPU entries (length of the clear walk)
//   BPU_IDX_W      width of a BPU entry index
//   BPU_QDEPTH     default depth of the resolution-update FIFO
//   BPU_CLEAR_TAG  pc_4 written while clearing; never a legal PC+4
//   bpu_upd_t      one branch-resolution update record (70 bits)
//   bpu_state_e    update controller states
package bpu_pkg;

  localparam int          BPU_ENTRIES   = 32;
  localparam int          BPU_IDX_W     = 5;
  localparam int          BPU_QDEPTH    = 4;
  localparam logic [31:0] BPU_CLEAR_TAG = 32'hFFFF_FFFF;

  // Field order matches the BPU write port: predict bit, index, tag, target.
  typedef struct packed {
    logic                 taken;
    logic [BPU_IDX_W-1:0] index;
    logic [31:0]          pc4;
    logic [31:0]          target;
  } bpu_upd_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bpu_state_e;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small synchronous FIFO holding branch-resolution updates until the BPU
// write port can take them.
//
// Ports:
//   clk, reset   core clock, asynchronous active-high reset
//   push_i       write data_i at the tail (ignored when full or flushing)
//   pop_i        advance the head (ignored when empty or flushing)
//   flush_i      discard every queued entry; wins over push and pop
//   data_i       record to enqueue
//   full_o       no free slot
//   empty_o      nothing queued
//   head_o       oldest record (meaningless while empty)
module bpu_upd_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPU_QDEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  bpu_upd_t data_i,
  output logic     full_o,
  output logic     empty_o,
  output bpu_upd_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  bpu_upd_t      mem_q [DEPTH];

  logic doPush;
  logic doPop;

  // The extra pointer bit tells a full queue from an empty one: same slot
  // with differing wrap bits means full, identical pointers mean empty.
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];

  assign doPush = push_i && !full_o && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  // Pointer bookkeeping; a flush simply collapses both pointers to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  // Storage slots; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Sequences every write into the branch prediction unit. After reset or a
// flush it walks all entries writing an invalid tag; otherwise it drains
// buffered branch resolutions from ID into the BPU one per unpaused cycle.
//
// Ports:
//   clk, reset      core clock, asynchronous active-high reset
//   pause_i         pipeline pause; suppresses BPU writes
//   flush_req_i     discard queued updates and restart the clear walk
//   res_*_i         branch resolution update from ID
//   res_ready_o     update FIFO has room
//   bpu_wen_o       [1]=write enable, [0]=predict bit
//   bpu_index_o     entry written
//   bpu_pc_4_o      tag written
//   bpu_target_o    target written
//   busy_o          clear walk in progress
//   drop_cnt_o      saturating count of updates lost to a full FIFO
module bpu_update_ctrl
  import bpu_pkg::*;
#(
  parameter int          ENTRIES   = BPU_ENTRIES,
  parameter int          QDEPTH    = BPU_QDEPTH,
  parameter logic [31:0] CLEAR_TAG = BPU_CLEAR_TAG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pause_i,
  input  logic                 flush_req_i,
  input  logic                 res_valid_i,
  input  logic                 res_taken_i,
  input  logic [BPU_IDX_W-1:0] res_index_i,
  input  logic [31:0]          res_pc_4_i,
  input  logic [31:0]          res_target_i,
  output logic                 res_ready_o,
  output logic [1:0]           bpu_wen_o,
  output logic [BPU_IDX_W-1:0] bpu_index_o,
  output logic [31:0]          bpu_pc_4_o,
  output logic [31:0]          bpu_target_o,
  output logic                 busy_o,
  output logic [7:0]           drop_cnt_o
);

  localparam logic [BPU_IDX_W-1:0] LAST_IDX = BPU_IDX_W'(ENTRIES - 1);

  bpu_state_e           state_q;
  logic [BPU_IDX_W-1:0] clrIdx_q;
  logic [7:0]           dropCnt_q;

  bpu_upd_t resRec;
  bpu_upd_t headRec;
  logic     fifoFull;
  logic     fifoEmpty;
  logic     fifoPush;
  logic     fifoPop;
  logic     dropNow;

  assign resRec = '{taken:  res_taken_i,
                    index:  res_index_i,
                    pc4:    res_pc_4_i,
                    target: res_target_i};

  // A push is judged against the registered full flag only, so a
  // same-cycle pop never makes room; that keeps pause_i out of res_ready_o.
  assign fifoPush = res_valid_i && !fifoFull && !flush_req_i;
  assign dropNow  = res_valid_i &&  fifoFull && !flush_req_i;
  assign fifoPop  = (state_q == ST_RUN) && !fifoEmpty && !pause_i;

  bpu_upd_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (flush_req_i),
    .data_i  (resRec),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (headRec)
  );

  // Controller FSM and clear-walk counter. A flush restarts the walk from
  // entry 0 even when a walk is already under way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      clrIdx_q <= '0;
    end else if (flush_req_i) begin
      state_q  <= ST_CLEAR;
      clrIdx_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (!pause_i) begin
            if (clrIdx_q == LAST_IDX) begin
              state_q  <= ST_RUN;
              clrIdx_q <= '0;
            end else begin
              clrIdx_q <= clrIdx_q + BPU_IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q  <= ST_CLEAR;
          clrIdx_q <= '0;
        end
      endcase
    end
  end

  // Drop counter survives flushes and saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCnt_q <= '0;
    end else if (dropNow && (dropCnt_q != 8'hFF)) begin
      dropCnt_q <= dropCnt_q + 8'd1;
    end
  end

  // BPU port mux: the clear pattern while walking, otherwise the FIFO head.
  always_comb begin
    bpu_wen_o    = 2'b00;
    bpu_index_o  = headRec.index;
    bpu_pc_4_o   = headRec.pc4;
    bpu_target_o = headRec.target;
    if (state_q == ST_CLEAR) begin
      bpu_wen_o    = 2'b10;
      bpu_index_o  = clrIdx_q;
      bpu_pc_4_o   = CLEAR_TAG;
      bpu_target_o = '0;
    end else if (!fifoEmpty) begin
      bpu_wen_o = {1'b1, headRec.taken};
    end
  end

  assign busy_o      = (state_q == ST_CLEAR);
  assign res_ready_o = !fifoFull;
  assign drop_cnt_o  = dropCnt_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl. A queue-based model of the BPU write
// sequencer is compared against the DUT on every falling edge, and a few
// hand-computed literal expectations pin the model to the intended behaviour.
module tb_bpu_update_ctrl;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause_i;
  logic        flush_req_i;
  logic        res_valid_i;
  logic        res_taken_i;
  logic [4:0]  res_index_i;
  logic [31:0] res_pc_4_i;
  logic [31:0] res_target_i;
  logic        res_ready_o;
  logic [1:0]  bpu_wen_o;
  logic [4:0]  bpu_index_o;
  logic [31:0] bpu_pc_4_o;
  logic [31:0] bpu_target_o;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  int checkCount = 0;
  int passCount  = 0;

  bpu_update_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pause_i      (pause_i),
    .flush_req_i  (flush_req_i),
    .res_valid_i  (res_valid_i),
    .res_taken_i  (res_taken_i),
    .res_index_i  (res_index_i),
    .res_pc_4_i   (res_pc_4_i),
    .res_target_i (res_target_i),
    .res_ready_o  (res_ready_o),
    .bpu_wen_o    (bpu_wen_o),
    .bpu_index_o  (bpu_index_o),
    .bpu_pc_4_o   (bpu_pc_4_o),
    .bpu_target_o (bpu_target_o),
    .busy_o       (busy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: whether a walk is running, how far it has got, the queued
  // updates in arrival order and the number of lost updates.
  bit       mClearing;
  int       mWalkPos;
  bpu_upd_t mQueue[$];
  int       mDrops;

  // Model advance. Everything is decided from the values seen just before
  // the edge: the head leaves if it was being written, a new update joins
  // only if the queue had fewer than four entries beforehand.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mClearing = 1'b1;
      mWalkPos  = 0;
      mQueue.delete();
      mDrops    = 0;
    end else if (flush_req_i) begin
      mClearing = 1'b1;
      mWalkPos  = 0;
      mQueue.delete();
    end else begin
      int  sizeBefore;
      bit  popNow;
      sizeBefore = mQueue.size();
      popNow     = !mClearing && (sizeBefore > 0) && !pause_i;
      if (popNow) void'(mQueue.pop_front());
      if (res_valid_i) begin
        if (sizeBefore >= 4) begin
          if (mDrops < 255) mDrops++;
        end else begin
          mQueue.push_back('{taken: res_taken_i, index: res_index_i,
                             pc4: res_pc_4_i, target: res_target_i});
        end
      end
      if (mClearing && !pause_i) begin
        mWalkPos++;
        if (mWalkPos == 32) begin
          mClearing = 1'b0;
          mWalkPos  = 0;
        end
      end
    end
  end

  // Compare process: checks the DUT port against the model every cycle.
  always @(negedge clk) begin
    checkOutput("busy", 32'(busy_o), 32'(mClearing));
    checkOutput("ready", 32'(res_ready_o), 32'(mQueue.size() < 4));
    checkOutput("drops", 32'(drop_cnt_o), 32'(mDrops));
    if (mClearing) begin
      checkOutput("clrWen", 32'(bpu_wen_o), 32'h2);
      checkOutput("clrIdx", 32'(bpu_index_o), 32'(mWalkPos));
      checkOutput("clrTag", bpu_pc_4_o, 32'hFFFF_FFFF);
      checkOutput("clrTgt", bpu_target_o, 32'h0);
    end else if (mQueue.size() > 0) begin
      checkOutput("updWen", 32'(bpu_wen_o), 32'({1'b1, mQueue[0].taken}));
      checkOutput("updIdx", 32'(bpu_index_o), 32'(mQueue[0].index));
      checkOutput("updPc4", bpu_pc_4_o, mQueue[0].pc4);
      checkOutput("updTgt", bpu_target_o, mQueue[0].target);
    end else begin
      checkOutput("idleWen", 32'(bpu_wen_o), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one resolution update (or none) for exactly one cycle.
  task automatic applyStimulus(input logic valid, input logic taken, input logic [4:0] idx,
                               input logic [31:0] pc4, input logic [31:0] tgt);
    res_valid_i  = valid;
    res_taken_i  = taken;
    res_index_i  = idx;
    res_pc_4_i   = pc4;
    res_target_i = tgt;
    tick();
    res_valid_i  = 1'b0;
  endtask

  // Counts cycles until the walk ends; gives up after 100.
  task automatic waitWalkDone(inout int n);
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Literal entries for the back-to-back push sequence.
  logic [4:0]  seqIdx [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
  logic [31:0] seqPc4 [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h900};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset        = 1'b1;
    pause_i      = 1'b0;
    flush_req_i  = 1'b0;
    res_valid_i  = 1'b0;
    res_taken_i  = 1'b0;
    res_index_i  = '0;
    res_pc_4_i   = '0;
    res_target_i = '0;
    tick();
    tick();
    checkOutput("rstWen", 32'(bpu_wen_o), 32'h2);
    checkOutput("rstIdx", 32'(bpu_index_o), 32'h0);
    checkOutput("rstReady", 32'(res_ready_o), 32'h1);
    reset = 1'b0;

    $display("[TB] clear walk after reset");
    n = 0;
    waitWalkDone(n);
    checkOutput("walkLen", 32'(n), 32'd32);
    checkOutput("walkIdleWen", 32'(bpu_wen_o), 32'h0);

    $display("[TB] paused clear walk");
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    repeat (10) tick();
    pause_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("pauseIdx", 32'(bpu_index_o), 32'd10);
      tick();
    end
    pause_i = 1'b0;
    n = 13;
    waitWalkDone(n);
    checkOutput("pausedWalkLen", 32'(n), 32'd35);

    $display("[TB] single update");
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h0040_0008, 32'h0040_0100);
    checkOutput("oneWen", 32'(bpu_wen_o), 32'h3);
    checkOutput("oneIdx", 32'(bpu_index_o), 32'd5);
    checkOutput("onePc4", bpu_pc_4_o, 32'h0040_0008);
    checkOutput("oneTgt", bpu_target_o, 32'h0040_0100);
    tick();
    checkOutput("oneAfterWen", 32'(bpu_wen_o), 32'h0);

    $display("[TB] overflow while paused");
    pause_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i[0], seqIdx[i], seqPc4[i], seqPc4[i] + 32'h10);
      if (i == 3) checkOutput("fullReady", 32'(res_ready_o), 32'h0);
    end
    checkOutput("dropOne", 32'(drop_cnt_o), 32'd1);
    pause_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainIdx", 32'(bpu_index_o), 32'(seqIdx[i]));
      checkOutput("drainWen", 32'(bpu_wen_o), 32'({1'b1, i[0]}));
      tick();
    end
    checkOutput("drainDoneWen", 32'(bpu_wen_o), 32'h0);

    $display("[TB] flush with queued entries");
    pause_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd7, 32'h700, 32'h710);
    applyStimulus(1'b1, 1'b1, 5'd8, 32'h800, 32'h810);
    flush_req_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd11, 32'hB00, 32'hB10);
    flush_req_i = 1'b0;
    pause_i     = 1'b0;
    checkOutput("flushBusy", 32'(busy_o), 32'h1);
    checkOutput("flushIdx", 32'(bpu_index_o), 32'h0);
    checkOutput("flushDrops", 32'(drop_cnt_o), 32'd1);
    n = 0;
    waitWalkDone(n);
    checkOutput("flushWalkLen", 32'(n), 32'd32);
    checkOutput("flushEmptyWen", 32'(bpu_wen_o), 32'h0);

    $display("[TB] reset mid-walk and mid-drain");
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    repeat (20) tick();
    checkOutput("midWalkIdx", 32'(bpu_index_o), 32'd20);
    reset = 1'b1;
    #1;
    checkOutput("rstWalkIdx", 32'(bpu_index_o), 32'h0);
    checkOutput("rstWalkDrops", 32'(drop_cnt_o), 32'h0);
    tick();
    reset = 1'b0;
    n = 0;
    waitWalkDone(n);
    checkOutput("rstWalkLen", 32'(n), 32'd32);
    pause_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd12, 32'hC00, 32'hC10);
    applyStimulus(1'b1, 1'b0, 5'd13, 32'hD00, 32'hD10);
    applyStimulus(1'b1, 1'b1, 5'd14, 32'hE00, 32'hE10);
    pause_i = 1'b0;
    tick();
    checkOutput("midDrainIdx", 32'(bpu_index_o), 32'd13);
    reset = 1'b1;
    #1;
    checkOutput("rstDrainWen", 32'(bpu_wen_o), 32'h2);
    checkOutput("rstDrainIdx", 32'(bpu_index_o), 32'h0);
    checkOutput("rstDrainBusy", 32'(busy_o), 32'h1);
    tick();
    reset = 1'b0;
    n = 0;
    waitWalkDone(n);
    checkOutput("finalWalkLen", 32'(n), 32'd32);
    checkOutput("finalEmptyWen", 32'(bpu_wen_o), 32'h0);
    tick();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
